// File: rtl/req_encoder.sv
// =============================================================================
// Module  : req_encoder
// Brief   : Buffers request strobes in a pending set and grants them one at a
//           time as binary indices over a valid/ready handshake.
//           Optional macro REQ_ENCODER_ROUND_ROBIN_EN selects round-robin
//           arbitration instead of fixed highest-index priority.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module req_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         drop
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         out_valid_q, out_valid_d;
  logic         drop_q, drop_d;
  logic [W-1:0] sel_idx;
  logic [N-1:0] grant_mask;
  logic         load;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] last_q, last_d;
  logic [W-1:0] probe;

  // Walk offsets from farthest to nearest so the first set bit after last wins.
  always_comb begin
    sel_idx = '0;
    probe   = '0;
    for (int k = N; k >= 1; k--) begin
      probe = last_q + W'(k);
      if (pending_q[probe]) sel_idx = probe;
    end
  end

  always_comb begin
    last_d = load ? sel_idx : last_q;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) sel_idx = W'(i);
    end
  end
`endif

  always_comb begin
    load        = (|pending_q) && ((state_q == S_IDLE) || out_ready);
    grant_mask  = load ? (C_ONE << sel_idx) : '0;
    // A strobe on the line being granted re-arms it rather than counting as a duplicate.
    pending_d   = (pending_q & ~grant_mask) | req;
    drop_d      = |(req & pending_q & ~grant_mask);
    out_idx_d   = load ? sel_idx : out_idx_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    if (load) begin
      state_d     = S_HOLD;
      out_valid_d = 1'b1;
    end else if ((state_q == S_HOLD) && out_ready) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      last_q      <= W'(N - 1);
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign drop      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_req_encoder.sv
// =============================================================================
// Module  : tb_req_encoder
// Brief   : Directed and random stimulus for req_encoder against a set-based
//           reference model. Honours REQ_ENCODER_ROUND_ROBIN_EN.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_req_encoder;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_ready;
  logic [N-1:0] pending;
  logic         drop;

  int total = 0;
  int bad   = 0;

  bit m_pend[N];
  bit m_valid;
  int m_idx;
  bit m_drop;
  int m_last;

  always #5 clk = ~clk;

  req_encoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .pending   (pending),
    .drop      (drop)
  );

  function automatic int pick();
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (m_pend[j]) return j;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input bit rdy, input bit rs);
    int g = -1;
    bit nd = 1'b0;
    if (rs) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_drop  = 1'b0;
      m_last  = N - 1;
    end else begin
      if (!m_valid || rdy) g = pick();
      for (int i = 0; i < N; i++) if (r[i] && m_pend[i] && i != g) nd = 1'b1;
      for (int i = 0; i < N; i++) m_pend[i] = (m_pend[i] && i != g) || r[i];
      m_drop = nd;
      if (g >= 0) begin
        m_valid = 1'b1;
        m_idx   = g;
        m_last  = g;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input bit rdy, input bit rs);
    req       = r;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    model_step(r, rdy, rs);
    #1;
    chk("model_valid",   32'(out_valid), 32'(m_valid));
    chk("model_idx",     32'(out_idx),   32'(m_idx));
    chk("model_pending", 32'(pending),   32'(pend_vec()));
    chk("model_drop",    32'(drop),      32'(m_drop));
  endtask

  initial begin
    int seq[3];
    logic [N-1:0] seen;
    logic [N-1:0] r;
    bit rdy, rs;

    rst = 1'b1; req = '0; out_ready = 1'b0;
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    chk("reset_valid",   32'(out_valid), 32'd0);
    chk("reset_idx",     32'(out_idx),   32'd0);
    chk("reset_pending", 32'(pending),   32'd0);
    chk("reset_drop",    32'(drop),      32'd0);

    // Single strobe: grant two edges after the strobe, for one cycle.
    cyc(8'h04, 1'b1, 1'b0);
    chk("single_pend", 32'(pending), 32'h04);
    chk("single_nv",   32'(out_valid), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_idx",   32'(out_idx),   32'd2);
    cyc(8'h00, 1'b1, 1'b0);
    chk("single_done_v", 32'(out_valid), 32'd0);
    chk("single_done_p", 32'(pending),   32'd0);

    // Three lines at once, from a fresh reset.
    cyc(8'h00, 1'b0, 1'b1);
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    seq = '{0, 4, 7};
`else
    seq = '{7, 4, 0};
`endif
    cyc(8'h91, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 1'b1, 1'b0);
      chk("multi_valid", 32'(out_valid), 32'd1);
      chk("multi_idx",   32'(out_idx),   32'(seq[i]));
    end
    cyc(8'h00, 1'b1, 1'b0);
    chk("multi_done", 32'(out_valid), 32'd0);

    // Backpressure.
    cyc(8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 1'b0, 1'b0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx",   32'(out_idx),   32'd3);
    end
    cyc(8'h00, 1'b1, 1'b0);
    chk("bp_accept", 32'(out_valid), 32'd0);

    // Duplicate strobe while a grant is held.
    cyc(8'h08, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h02, 1'b0, 1'b0);
    chk("dup_first", 32'(drop), 32'd0);
    cyc(8'h02, 1'b0, 1'b0);
    chk("dup_drop", 32'(drop), 32'd1);
    cyc(8'h00, 1'b0, 1'b0);
    chk("dup_pulse", 32'(drop), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("dup_grant_v", 32'(out_valid), 32'd1);
    chk("dup_grant_i", 32'(out_idx),   32'd1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("dup_once", 32'(out_valid), 32'd0);

    // Re-assert on the loading cycle.
    cyc(8'h20, 1'b1, 1'b0);
    cyc(8'h20, 1'b1, 1'b0);
    chk("sim_idx",  32'(out_idx), 32'd5);
    chk("sim_pend", 32'(pending), 32'h20);
    chk("sim_drop", 32'(drop),    32'd0);
    cyc(8'h00, 1'b1, 1'b0);
    chk("sim_again_v", 32'(out_valid), 32'd1);
    chk("sim_again_i", 32'(out_idx),   32'd5);
    cyc(8'h00, 1'b1, 1'b0);
    chk("sim_done", 32'(out_valid), 32'd0);

    // All lines at once: N back-to-back grants, each line once.
    cyc(8'hFF, 1'b1, 1'b0);
    seen = '0;
    for (int i = 0; i < N; i++) begin
      cyc(8'h00, 1'b1, 1'b0);
      chk("all_valid", 32'(out_valid), 32'd1);
      chk("all_drop",  32'(drop),      32'd0);
      seen[out_idx] = 1'b1;
    end
    chk("all_seen", 32'(seen), 32'hFF);
    cyc(8'h00, 1'b1, 1'b0);
    chk("all_done", 32'(out_valid), 32'd0);

    // Reset while full and holding a grant.
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    chk("full_pend",  32'(pending),   32'hFF);
    chk("full_valid", 32'(out_valid), 32'd1);
    cyc(8'hFF, 1'b1, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_idx",   32'(out_idx),   32'd0);
    chk("mid_rst_pend",  32'(pending),   32'd0);
    chk("mid_rst_drop",  32'(drop),      32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 1'b1, 1'b0);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      r   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 79) == 0);
      cyc(r, rdy, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
